// File: rtl/mcdt_rx_pkg.sv
// mcdt_rx_pkg: shared constants and types for the MCDT receive demultiplexer.
package mcdt_rx_pkg;
    localparam int CH_NUM = 3;
    typedef logic [1:0] ch_id_t;
    typedef logic [5:0] margin_t;
    localparam ch_id_t ID_ILLEGAL = 2'd3;
endpackage

// File: rtl/mcdt_rx_if.sv
// mcdt_rx_if: arbitrated MCDT word stream; no ready, the source never stalls.
interface mcdt_rx_if
    import mcdt_rx_pkg::*;
#(
    parameter int DW = 32
);
    logic [DW-1:0] mcdt_data_i;
    logic          mcdt_val_i;
    ch_id_t        mcdt_id_i;
    modport master (output mcdt_data_i, mcdt_val_i, mcdt_id_i);
    modport slave  (input  mcdt_data_i, mcdt_val_i, mcdt_id_i);
endinterface

// File: rtl/mcdt_rx_fifo.sv
// mcdt_rx_fifo: single-clock per-channel FIFO; a push into a full FIFO is taken
// only when the head is popped in the same cycle.
module mcdt_rx_fifo
    import mcdt_rx_pkg::*;
#(
    parameter  int DEPTH = 32,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          ready,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          wr,
    output margin_t       margin
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          full, rd;

    assign valid  = cnt != '0;
    assign full   = cnt == (AW+1)'(DEPTH);
    assign rd     = valid && ready;
    assign wr     = push && (!full || rd);
    assign dout   = valid ? mem[rptr] : '0;
    assign margin = margin_t'(DEPTH) - margin_t'(cnt);

    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end

    // storage needs no reset: entries are only read while counted
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= din;
endmodule

// File: rtl/mcdt_rx.sv
// mcdt_rx: steers the MCDT stream into three receive FIFOs with sticky loss flags.
// Define MCDT_RX_STATS_EN to add per-channel accepted-word counters.
module mcdt_rx
    import mcdt_rx_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr_i,
    mcdt_rx_if.slave      stream,
    output logic [DW-1:0] ch0_data_o,
    output logic          ch0_valid_o,
    input  logic          ch0_ready_i,
    output margin_t       ch0_margin_o,
    output logic          ch0_ovf_o,
    output logic [DW-1:0] ch1_data_o,
    output logic          ch1_valid_o,
    input  logic          ch1_ready_i,
    output margin_t       ch1_margin_o,
    output logic          ch1_ovf_o,
    output logic [DW-1:0] ch2_data_o,
    output logic          ch2_valid_o,
    input  logic          ch2_ready_i,
    output margin_t       ch2_margin_o,
    output logic          ch2_ovf_o,
`ifdef MCDT_RX_STATS_EN
    output logic [15:0]   ch0_cnt_o,
    output logic [15:0]   ch1_cnt_o,
    output logic [15:0]   ch2_cnt_o,
`endif
    output logic          id_err_o
);
    logic [CH_NUM-1:0] push, rdy, vld, wr, ovf;
    logic [DW-1:0]     dat [CH_NUM];
    margin_t           mg  [CH_NUM];
    logic              ill;

    assign rdy = {ch2_ready_i, ch1_ready_i, ch0_ready_i};
    assign ill = stream.mcdt_val_i && stream.mcdt_id_i == ID_ILLEGAL;

    for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
        assign push[n] = stream.mcdt_val_i && stream.mcdt_id_i == ch_id_t'(n);
        mcdt_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
            .clk    (clk),
            .rstn   (rstn),
            .push   (push[n]),
            .ready  (rdy[n]),
            .din    (stream.mcdt_data_i),
            .dout   (dat[n]),
            .valid  (vld[n]),
            .wr     (wr[n]),
            .margin (mg[n])
        );
    end

    // a new event in the clearing cycle keeps its flag set
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            ovf      <= '0;
            id_err_o <= 1'b0;
        end else begin
            ovf      <= (push & ~wr) | (ovf & {CH_NUM{!clr_i}});
            id_err_o <= ill || (id_err_o && !clr_i);
        end

    assign ch0_data_o   = dat[0];
    assign ch1_data_o   = dat[1];
    assign ch2_data_o   = dat[2];
    assign ch0_valid_o  = vld[0];
    assign ch1_valid_o  = vld[1];
    assign ch2_valid_o  = vld[2];
    assign ch0_margin_o = mg[0];
    assign ch1_margin_o = mg[1];
    assign ch2_margin_o = mg[2];
    assign ch0_ovf_o    = ovf[0];
    assign ch1_ovf_o    = ovf[1];
    assign ch2_ovf_o    = ovf[2];

`ifdef MCDT_RX_STATS_EN
    logic [15:0] cnt [CH_NUM];

    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            for (int n = 0; n < CH_NUM; n++) cnt[n] <= '0;
        end else begin
            for (int n = 0; n < CH_NUM; n++) cnt[n] <= (clr_i ? 16'd0 : cnt[n]) + 16'(wr[n]);
        end

    assign ch0_cnt_o = cnt[0];
    assign ch1_cnt_o = cnt[1];
    assign ch2_cnt_o = cnt[2];
`endif
endmodule

// File: tb/tb_mcdt_rx.sv
// tb_mcdt_rx: directed stimulus feeding per-channel expectation queues; a negedge
// monitor pops and compares every word the DUT hands to a consumer.
module tb_mcdt_rx;
    import mcdt_rx_pkg::*;

    logic              clk, rstn, clr;
    logic [2:0]        rdy, vld, ovf;
    logic [2:0][31:0]  dat;
    logic [2:0][5:0]   mg;
    logic              id_err;
`ifdef MCDT_RX_STATS_EN
    logic [2:0][15:0]  cnt;
`endif
    logic [31:0]       q [3][$];
    int                checks = 0, fails = 0;

    mcdt_rx_if #(.DW(32)) bus ();

    mcdt_rx #(.DEPTH(32), .DW(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clr_i        (clr),
        .stream       (bus.slave),
        .ch0_data_o   (dat[0]),
        .ch0_valid_o  (vld[0]),
        .ch0_ready_i  (rdy[0]),
        .ch0_margin_o (mg[0]),
        .ch0_ovf_o    (ovf[0]),
        .ch1_data_o   (dat[1]),
        .ch1_valid_o  (vld[1]),
        .ch1_ready_i  (rdy[1]),
        .ch1_margin_o (mg[1]),
        .ch1_ovf_o    (ovf[1]),
        .ch2_data_o   (dat[2]),
        .ch2_valid_o  (vld[2]),
        .ch2_ready_i  (rdy[2]),
        .ch2_margin_o (mg[2]),
        .ch2_ovf_o    (ovf[2]),
`ifdef MCDT_RX_STATS_EN
        .ch0_cnt_o    (cnt[0]),
        .ch1_cnt_o    (cnt[1]),
        .ch2_cnt_o    (cnt[2]),
`endif
        .id_err_o     (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // a pop happens at the next rising edge whenever valid and ready are both high here
    always @(negedge clk)
        if (!rstn)
            for (int n = 0; n < 3; n++)
                if (vld[n] && rdy[n]) begin
                    if (q[n].size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL ch%0d_unexpected_word: got %h, expected no word", n, dat[n]);
                    end else
                        chk($sformatf("ch%0d_order", n), dat[n], q[n].pop_front());
                end

    task automatic send(input logic [1:0] id, input logic [31:0] d);
        bus.mcdt_val_i  = 1'b1;
        bus.mcdt_id_i   = id;
        bus.mcdt_data_i = d;
        @(posedge clk);
        #1;
        bus.mcdt_val_i  = 1'b0;
    endtask

    task automatic drain(input int ch);
        int k = 0;
        rdy[ch] = 1'b1;
        while (q[ch].size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        rdy[ch] = 1'b0;
        chk($sformatf("ch%0d_drain_left", ch), q[ch].size(), 0);
        chk($sformatf("ch%0d_margin_empty", ch), mg[ch], 32);
    endtask

    initial begin
        rstn = 1'b1;
        clr  = 1'b0;
        rdy  = '0;
        bus.mcdt_val_i  = 1'b0;
        bus.mcdt_id_i   = 2'd0;
        bus.mcdt_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("rst_ch%0d_valid", n), vld[n], 0);
            chk($sformatf("rst_ch%0d_data", n), dat[n], 0);
            chk($sformatf("rst_ch%0d_margin", n), mg[n], 32);
            chk($sformatf("rst_ch%0d_ovf", n), ovf[n], 0);
        end
        chk("rst_id_err", id_err, 0);

        // routing to ch1, consumer stalled
        for (int i = 0; i < 10; i++) begin
            q[1].push_back(32'h00C1_0000 + i);
            send(2'd1, 32'h00C1_0000 + i);
            chk("ch1_valid_after_write", vld[1], 1);
            chk("ch1_head", dat[1], 32'h00C1_0000);
            chk("ch1_margin_fill", mg[1], 32'(31 - i));
        end
        chk("ch1_margin_10", mg[1], 22);
        chk("ch0_valid_idle", vld[0], 0);
        chk("ch2_valid_idle", vld[2], 0);
        drain(1);

        // overflow of ch0
        for (int i = 0; i < 33; i++) begin
            if (i < 32) q[0].push_back(32'h00C0_0000 + i);
            send(2'd0, 32'h00C0_0000 + i);
            if (i == 31) begin
                chk("ch0_margin_full", mg[0], 0);
                chk("ch0_ovf_before_drop", ovf[0], 0);
            end
        end
        chk("ch0_ovf_set", ovf[0], 1);
        chk("ch0_margin_after_drop", mg[0], 0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("ch0_ovf_cleared", ovf[0], 0);
        drain(0);

        // ch2 full, push with simultaneous pop
        for (int i = 0; i < 32; i++) begin
            q[2].push_back(32'h00C2_0000 + i);
            send(2'd2, 32'h00C2_0000 + i);
        end
        chk("ch2_margin_full", mg[2], 0);
        rdy[2] = 1'b1;
        q[2].push_back(32'h00C2_00FF);
        send(2'd2, 32'h00C2_00FF);
        rdy[2] = 1'b0;
        chk("ch2_ovf_push_pop", ovf[2], 0);
        chk("ch2_margin_push_pop", mg[2], 0);
        drain(2);

        // illegal id
        send(2'd3, 32'hDEAD_BEEF);
        chk("id_err_set", id_err, 1);
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("id3_ch%0d_margin", n), mg[n], 32);
            chk($sformatf("id3_ch%0d_valid", n), vld[n], 0);
        end
        clr = 1'b1;
        send(2'd3, 32'hDEAD_BEEF);
        clr = 1'b0;
        chk("id_err_set_wins", id_err, 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("id_err_cleared", id_err, 0);

        // interleaved traffic, random consumers
        for (int i = 0; i < 30; i++) begin
            int id = i % 3;
            logic [31:0] d = 32'h00D0_0000 + 32'(id << 8) + 32'(i);
            for (int n = 0; n < 3; n++) rdy[n] = 1'($urandom_range(0, 1));
            q[id].push_back(d);
            send(2'(id), d);
        end
        rdy = '0;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("mix_ch%0d_ovf", n), ovf[n], 0);
            drain(n);
        end
`ifdef MCDT_RX_STATS_EN
        for (int n = 0; n < 3; n++) chk($sformatf("ch%0d_cnt", n), cnt[n], 10);
`endif

        // reset mid-stream
        for (int i = 0; i < 5; i++) send(2'd0, 32'h00C0_1000 + i);
        chk("ch0_margin_5", mg[0], 27);
        rstn = 1'b1;
        #1;
        chk("midrst_ch0_valid", vld[0], 0);
        chk("midrst_ch0_margin", mg[0], 32);
        send(2'd0, 32'h0000_BAD0);
        send(2'd3, 32'h0000_BAD3);
        chk("midrst_drop_margin", mg[0], 32);
        chk("midrst_drop_ovf", ovf[0], 0);
        chk("midrst_drop_id_err", id_err, 0);
        rstn = 1'b0;
        q[0].push_back(32'h00C0_0ABC);
        send(2'd0, 32'h00C0_0ABC);
        chk("postrst_ch0_valid", vld[0], 1);
        chk("postrst_ch0_head", dat[0], 32'h00C0_0ABC);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mcdt_rx.md
# mcdt_rx

Receive-side demultiplexer for the multi-channel data transfer (MCDT) stream. It accepts the arbitrated word stream of `mcdt_data`, `mcdt_val` and `mcdt_id`, and steers each word into one of three per-channel receive FIFOs. Each FIFO presents its words to a downstream consumer over a valid/ready handshake. The source stream has no backpressure, so the block reports free space per channel and flags lost words and illegal IDs.

## Interface
Parameters:
- `DEPTH`, default 32: entries per channel FIFO; power of two, 4..32.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rstn`  in  1  reset; asynchronous, active-high.
- `clr_i`  in  1  synchronous pulse; clears the sticky flags.
- `mcdt_data_i`  in  DW  stream word.
- `mcdt_val_i`  in  1  stream word valid; no ready exists.
- `mcdt_id_i`  in  2  destination channel; 0..2 legal, 3 illegal.
- `chN_data_o`  out  DW  FIFO head word (N = 0, 1, 2, one port per channel).
- `chN_valid_o`  out  1  FIFO N not empty.
- `chN_ready_i`  in  1  consumer N accepts the head word.
- `chN_margin_o`  out  6  free entries, DEPTH − count.
- `chN_ovf_o`  out  1  sticky: word to channel N dropped because FIFO full.
- `id_err_o`  out  1  sticky: `mcdt_val_i` asserted with `mcdt_id_i` = 3.

## Operation
- Write: when `mcdt_val_i` = 1 and `mcdt_id_i` = N < 3, the word is offered to FIFO N.
  - It is written if FIFO N is not full, or if it is full and a pop of FIFO N occurs in the same cycle.
  - Otherwise the word is discarded and `chN_ovf_o` is set.
- Illegal ID: when `mcdt_id_i` = 3 with valid, the word is discarded, `id_err_o` is set, and no FIFO changes.
- Pop: a pop of channel N occurs when `chN_valid_o` and `chN_ready_i` are both 1 at a rising edge; the head advances.
- Ordering: strict in-order per channel. There is no ordering relation between channels.
- Count arithmetic: count is $clog2(DEPTH)+1 bits.
  - Push only: +1. Pop only: −1. Both: unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Sticky flags clear on `clr_i`. If `clr_i` and a new error event occur in the same cycle, set wins.
- `chN_ready_i` while `chN_valid_o` = 0 is ignored.

## Timing
- Reset values:
  - `chN_valid_o` = 0, `chN_data_o` = 0, `chN_margin_o` = DEPTH, all flags = 0.
  - Pointers and counts are 0; FIFO contents are don't-care.
- Latency: a word written at edge k is visible on `chN_data_o` with `chN_valid_o` = 1 after edge k, i.e. one cycle. There is no combinational bypass.
- `chN_data_o` is stable while `chN_valid_o` = 1 and no pop occurs.
- `chN_margin_o` and `chN_valid_o` are registered and update in the cycle after the push or pop.
- Full with push and pop in the same cycle: the word is accepted and the margin stays 0.
- Empty with a push: no pop is possible in that cycle.
- Reset asserted mid-operation: all FIFOs empty immediately (asynchronous). Stream words presented during reset are dropped silently, with no flags set.

## Configuration
- `MCDT_RX_STATS_EN` defined:
  - Adds outputs `chN_cnt_o [15:0]`, one per channel, counting accepted words.
  - Counters wrap from 0xFFFF to 0, reset to 0, and are cleared by `clr_i`.
  - Dropped and illegal words are not counted.
- Not defined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package `mcdt_rx_pkg` holds:
  - `CH_NUM` = 3, `ID_ILLEGAL` = 2'd3.
  - Typedef `ch_id_t` (2 bits) and typedef `margin_t` (6 bits).
- Sub-module `mcdt_rx_fifo`: a single-clock synchronous FIFO with push/pop, full/empty, count and margin. It is instantiated three times.
- The top level holds the ID decode, sticky flags and optional counters.

## Test plan
- **Per-channel routing:** after reset, send ten words 0x00C1_0000..0x00C1_0009 with id = 1.
  - ch1 outputs them in order, each one cycle after write.
  - ch0 and ch2 valid stay 0.
  - `ch1_margin_o` reaches 22 with `ch1_ready_i` = 0.
- **Overflow:** hold `ch0_ready_i` = 0 and send 33 words 0x00C0_0000..0x00C0_0020 to id 0.
  - The first 32 are stored and the margin reads 0.
  - The 33rd word (0x00C0_0020) is dropped and `ch0_ovf_o` = 1.
  - After `clr_i`, `ch0_ovf_o` = 0.
- **Full with simultaneous push and pop:** fill ch2 to 32, then push 0x00C2_00FF in the same cycle as a pop.
  - No overflow; the margin stays 0.
  - 0x00C2_00FF is the last of 32 words drained.
- **Illegal ID:** send 0xDEAD_BEEF with id = 3.
  - `id_err_o` = 1 next cycle; all margins are unchanged.
  - Pulse `clr_i` together with another id-3 word: `id_err_o` remains 1.
- **Interleaved traffic:** rotate ids 0, 1, 2 every cycle for 30 cycles with random consumer ready.
  - Each channel outputs its 10 words in order with no loss.
  - With `MCDT_RX_STATS_EN`, each `chN_cnt_o` = 10.
- **Reset mid-stream:** with 5 words queued in ch0, assert `rstn`.
  - `ch0_valid_o` = 0 and `ch0_margin_o` = 32 immediately.
  - After release, the next word written is the first word output.
